wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter. The pipeline WB stage always wins the register-file
// write port. The multicycle aux unit is granted on free cycles. After a run of
// MAX_WAIT denied aux cycles, the arbiter asks the hazard unit for a WB bubble.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        aux_req,
    input  logic [4:0]  aux_waddr,
    input  logic [31:0] aux_wdata,
    output logic        aux_ack,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_sel,
    output logic [15:0] aux_grant_cnt
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  wcnt_inc;
    logic        aux_ack_q;
    logic        stall_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        wb_sel_q;
    logic [15:0] grant_cnt_q;
    logic        aux_live;
    logic        aux_grant;
    logic        aux_denied;

    // A held aux_req is ignored in its ack cycle so it cannot be granted twice.
    assign aux_live   = aux_req & ~aux_ack_q;
    assign aux_grant  = aux_live & ~pipe_we;
    assign aux_denied = aux_live & pipe_we;
    assign wcnt_inc   = wcnt_q + 4'd1;

    // Starvation FSM next-state logic.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (aux_denied) begin
                    wcnt_d = 4'd1;
                    if (MaxWait == 4'd1) begin
                        state_d = StForce;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (aux_grant) begin
                    state_d = StIdle;
                    wcnt_d  = 4'd0;
                end else if (aux_denied) begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == MaxWait) begin
                        state_d = StForce;
                    end
                end
            end
            StForce: begin
                if (aux_grant) begin
                    state_d = StIdle;
                    wcnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = StIdle;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // FSM state, wait counter and the registered stall request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wcnt_q  <= 4'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= (state_d == StForce);
        end
    end

    // Registered write port; r0 writes are granted but never enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            wb_sel_q   <= 1'b0;
            aux_ack_q  <= 1'b0;
        end else begin
            aux_ack_q <= aux_grant;
            if (pipe_we) begin
                rf_we_q    <= (pipe_waddr != 5'd0);
                rf_waddr_q <= pipe_waddr;
                rf_wdata_q <= pipe_wdata;
                wb_sel_q   <= 1'b0;
            end else if (aux_grant) begin
                rf_we_q    <= (aux_waddr != 5'd0);
                rf_waddr_q <= aux_waddr;
                rf_wdata_q <= aux_wdata;
                wb_sel_q   <= 1'b1;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    // Free-running count of aux grants, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= 16'd0;
        end else if (aux_grant) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign aux_ack       = aux_ack_q;
    assign stall_req     = stall_q;
    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign wb_sel        = wb_sel_q;
    assign aux_grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model of the port rules.
module tb_wb_port_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        aux_req;
    logic [4:0]  aux_waddr;
    logic [31:0] aux_wdata;
    logic        aux_ack;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_sel;
    logic [15:0] aux_grant_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: registered outputs plus the length of the current
    // run of denied aux cycles since the last aux grant.
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_sel;
    logic        m_ack;
    logic [15:0] m_cnt;
    int          m_streak;

    wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_we       (pipe_we),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .aux_req       (aux_req),
        .aux_waddr     (aux_waddr),
        .aux_wdata     (aux_wdata),
        .aux_ack       (aux_ack),
        .stall_req     (stall_req),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .wb_sel        (wb_sel),
        .aux_grant_cnt (aux_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_addr = 0; m_data = 0; m_sel = 0; m_ack = 0; m_cnt = 0;
        m_streak = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".rf_we"}, 32'(rf_we), 32'(m_we));
        chk({ctx, ".rf_waddr"}, 32'(rf_waddr), 32'(m_addr));
        chk({ctx, ".rf_wdata"}, rf_wdata, m_data);
        chk({ctx, ".wb_sel"}, 32'(wb_sel), 32'(m_sel));
        chk({ctx, ".aux_ack"}, 32'(aux_ack), 32'(m_ack));
        chk({ctx, ".stall_req"}, 32'(stall_req), 32'(m_streak >= int'(MAX_WAIT)));
        chk({ctx, ".aux_grant_cnt"}, 32'(aux_grant_cnt), 32'(m_cnt));
    endtask

    // Apply current inputs for one clock, advance the model, then compare.
    task automatic step(input string ctx);
        bit live;
        bit ag;
        live = aux_req && !m_ack;
        ag   = live && !pipe_we;
        if (pipe_we) begin
            m_we = (pipe_waddr != 0); m_addr = pipe_waddr; m_data = pipe_wdata; m_sel = 0;
        end else if (ag) begin
            m_we = (aux_waddr != 0); m_addr = aux_waddr; m_data = aux_wdata; m_sel = 1;
        end else begin
            m_we = 0;
        end
        m_ack = ag;
        if (ag) begin
            m_cnt++;
            m_streak = 0;
        end else if (live) begin
            m_streak++;
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        bit drop_next;
        clk = 0; reset = 1;
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        aux_req = 0; aux_waddr = 0; aux_wdata = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 0;

        // Pipeline-only write.
        pipe_we = 1; pipe_waddr = 5; pipe_wdata = 32'hDEADBEEF;
        step("pipe_only");
        chk("pipe_only.data_lit", rf_wdata, 32'hDEADBEEF);

        // Aux-only write.
        pipe_we = 0; aux_req = 1; aux_waddr = 9; aux_wdata = 32'h12345678;
        step("aux_only");
        chk("aux_only.ack_lit", 32'(aux_ack), 32'd1);
        chk("aux_only.cnt_lit", 32'(aux_grant_cnt), 32'd1);
        aux_req = 1;
        step("aux_masked");
        aux_req = 0;
        step("idle_hold");

        // Starvation: six denied cycles, then the pipeline backs off.
        pipe_we = 1; aux_req = 1; aux_waddr = 17; aux_wdata = 32'hA5A5_0001;
        for (int i = 0; i < 6; i++) begin
            pipe_waddr = 5'(i + 1); pipe_wdata = 32'(i) ^ 32'hF0F0_0000;
            step("starve");
        end
        chk("starve.stall_lit", 32'(stall_req), 32'd1);
        pipe_we = 0;
        step("starve_release");
        chk("starve_release.stall_lit", 32'(stall_req), 32'd0);
        aux_req = 0;
        step("starve_idle");

        // Aux write to r0 is acked but not enabled.
        aux_req = 1; aux_waddr = 0; aux_wdata = 32'h0BAD_F00D;
        step("aux_r0");
        chk("aux_r0.we_lit", 32'(rf_we), 32'd0);
        aux_req = 0;
        step("aux_r0_idle");

        // Random traffic obeying the aux handshake.
        drop_next = 0;
        for (int i = 0; i < 3000; i++) begin
            pipe_we = ($urandom_range(0, 9) < 7);
            pipe_waddr = 5'($urandom_range(0, 31));
            pipe_wdata = $urandom;
            if (!aux_req || drop_next) begin
                aux_req   = ($urandom_range(0, 2) != 0);
                aux_waddr = 5'($urandom_range(0, 31));
                aux_wdata = $urandom;
            end
            step("rand");
            drop_next = aux_req && m_ack;
        end
        pipe_we = 0; aux_req = 0;
        step("rand_end");
        step("rand_end2");

        // Reset while in FORCE clears outputs without a clock edge.
        pipe_we = 1; aux_req = 1; aux_waddr = 3; aux_wdata = 32'h3333_3333;
        for (int i = 0; i < 5; i++) step("force_setup");
        chk("force_setup.stall_lit", 32'(stall_req), 32'd1);
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        model_reset();
        chk("async_rst.stall_req", 32'(stall_req), 32'd0);
        chk("async_rst.aux_ack", 32'(aux_ack), 32'd0);
        chk("async_rst.cnt", 32'(aux_grant_cnt), 32'd0);
        chk("async_rst.rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        reset = 0;
        pipe_we = 0;
        step("post_rst_grant");
        chk("post_rst_grant.ack_lit", 32'(aux_ack), 32'd1);
        aux_req = 0;
        step("post_rst_idle");

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.grant_cnt_q = 16'hFFFF;
        #1;
        release dut.grant_cnt_q;
        m_cnt = 16'hFFFF;
        #1;
        chk("wrap.preload", 32'(aux_grant_cnt), 32'h0000_FFFF);
        aux_req = 1; aux_waddr = 12; aux_wdata = 32'hC0DE_0012;
        step("wrap");
        chk("wrap.cnt_lit", 32'(aux_grant_cnt), 32'd0);
        aux_req = 0;
        step("wrap_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
